// File: rtl/dff_en_pipe.sv
// Enable-gated register pipeline of DEPTH stages, each stage carrying WIDTH data bits
// and a valid bit, with synchronous flush and live occupancy reporting.
module dff_en_pipe #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter bit ZERO_INVALID = 1'b1,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [OCC_W-1:0] occupancy,
    output logic             active
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [OCC_W-1:0] occ_s;

    // Next-state: flush beats enable; enable shifts one stage toward the output.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = '0;
            if (ZERO_INVALID) begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_d[i] = '0;
                end
            end else begin
                data_d = data_q;
            end
        end else if (en) begin
            vld_d[0]  = d_valid;
            data_d[0] = (ZERO_INVALID && !d_valid) ? '0 : d;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i]  = vld_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end else begin
            data_d = data_q;
            vld_d  = vld_q;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q <= vld_d;
        end
    end

    // Popcount of the valid bits; no register so it tracks vld in the same cycle.
    always_comb begin
        occ_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_s = occ_s + OCC_W'(vld_q[i]);
        end
    end

    assign q         = data_q[DEPTH-1];
    assign q_valid   = vld_q[DEPTH-1];
    assign occupancy = occ_s;
    assign active    = |vld_q;

endmodule

// File: tb/tb_dff_en_pipe.sv
// Self-checking bench for dff_en_pipe: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_dff_en_pipe;

    logic       clk = 1'b0;
    logic       rst, en, flush, d_valid;
    logic [7:0] d;

    logic [7:0] m_q, z_q;
    logic       m_qv, z_qv, m_act, z_act;
    logic [2:0] m_occ, z_occ;
    logic       g_q, g_qv, g_occ, g_act;

    always #5 clk = ~clk;

    dff_en_pipe #(.WIDTH(8), .DEPTH(4), .ZERO_INVALID(1'b1)) u_main (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(m_q), .q_valid(m_qv), .occupancy(m_occ), .active(m_act)
    );

    dff_en_pipe #(.WIDTH(8), .DEPTH(4), .ZERO_INVALID(1'b0)) u_zi0 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(z_q), .q_valid(z_qv), .occupancy(z_occ), .active(z_act)
    );

    dff_en_pipe #(.WIDTH(1), .DEPTH(1), .ZERO_INVALID(1'b0)) u_deg (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d[0]), .d_valid(d_valid),
        .q(g_q), .q_valid(g_qv), .occupancy(g_occ), .active(g_act)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: each pipeline is a queue, front = stage 0, back = output stage.
    typedef struct packed {
        logic       v;
        logic [7:0] dt;
    } ent_t;

    ent_t pipe [3][$];

    function automatic int depth_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit zi_of(input int k);
        return (k == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pipe[k].delete();
            for (int i = 0; i < depth_of(k); i++) pipe[k].push_back('0);
        end
    endtask

    task automatic model_edge(input logic e, input logic f, input logic [7:0] dd, input logic dv);
        ent_t n;
        for (int k = 0; k < 3; k++) begin
            if (f) begin
                for (int i = 0; i < pipe[k].size(); i++) begin
                    pipe[k][i].v = 1'b0;
                    if (zi_of(k)) pipe[k][i].dt = 8'h00;
                end
            end else if (e) begin
                n.v  = dv;
                n.dt = (k == 2) ? {7'b0, dd[0]} : dd;
                if (zi_of(k) && !dv) n.dt = 8'h00;
                pipe[k].push_front(n);
                void'(pipe[k].pop_back());
            end
        end
    endtask

    function automatic int model_occ(input int k);
        int c = 0;
        foreach (pipe[k][i]) c += int'(pipe[k][i].v);
        return c;
    endfunction

    task automatic check_model();
        ent_t o;
        int   oc;
        for (int k = 0; k < 3; k++) begin
            o  = pipe[k][pipe[k].size() - 1];
            oc = model_occ(k);
            case (k)
                0: begin
                    check("rnd_main_q", m_q, o.dt);
                    check("rnd_main_qv", 8'(m_qv), 8'(o.v));
                    check("rnd_main_occ", 8'(m_occ), 8'(oc));
                    check("rnd_main_act", 8'(m_act), 8'(oc != 0));
                end
                1: begin
                    check("rnd_zi0_q", z_q, o.dt);
                    check("rnd_zi0_qv", 8'(z_qv), 8'(o.v));
                    check("rnd_zi0_occ", 8'(z_occ), 8'(oc));
                    check("rnd_zi0_act", 8'(z_act), 8'(oc != 0));
                end
                default: begin
                    check("rnd_deg_q", 8'(g_q), o.dt);
                    check("rnd_deg_qv", 8'(g_qv), 8'(o.v));
                    check("rnd_deg_occ", 8'(g_occ), 8'(oc));
                    check("rnd_deg_act", 8'(g_act), 8'(oc != 0));
                end
            endcase
        end
    endtask

    task automatic step(input logic e, input logic f, input logic [7:0] dd, input logic dv);
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        model_edge(e, f, dd, dv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic       fl;
        logic [7:0] d;
        logic       dv;
        logic [7:0] q;
        logic       qv;
        logic [2:0] occ;
    } vec_t;

    vec_t tbl [29];

    initial begin
        // {en, flush, d, d_valid} -> {q, q_valid, occupancy} after the edge, main instance
        tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2};
        tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 3'd3};
        tbl[3]  = '{1'b1, 1'b0, 8'h44, 1'b1, 8'h11, 1'b1, 3'd4};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 3'd3};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 3'd2};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 3'd1};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[10] = '{1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[11] = '{1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd1};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[16] = '{1'b1, 1'b0, 8'h0F, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[17] = '{1'b1, 1'b0, 8'h0F, 1'b0, 8'h00, 1'b0, 3'd1};
        tbl[18] = '{1'b1, 1'b0, 8'h0F, 1'b1, 8'h00, 1'b0, 3'd2};
        tbl[19] = '{1'b1, 1'b0, 8'h0F, 1'b0, 8'h0F, 1'b1, 3'd2};
        tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1};
        tbl[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0F, 1'b1, 3'd1};
        tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[23] = '{1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[24] = '{1'b1, 1'b0, 8'h02, 1'b1, 8'h00, 1'b0, 3'd2};
        tbl[25] = '{1'b1, 1'b0, 8'h03, 1'b1, 8'h00, 1'b0, 3'd3};
        tbl[26] = '{1'b1, 1'b0, 8'h04, 1'b1, 8'h01, 1'b1, 3'd4};
        tbl[27] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[28] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};

        rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
        do_reset();
        check("reset_q", m_q, 8'h00);
        check("reset_qv", 8'(m_qv), 8'h00);
        check("reset_occ", 8'(m_occ), 8'h00);
        check("reset_act", 8'(m_act), 8'h00);

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].en, tbl[i].fl, tbl[i].d, tbl[i].dv);
            check($sformatf("vec%0d_q", i), m_q, tbl[i].q);
            check($sformatf("vec%0d_qv", i), 8'(m_qv), 8'(tbl[i].qv));
            check($sformatf("vec%0d_occ", i), 8'(m_occ), 8'(tbl[i].occ));
            check($sformatf("vec%0d_act", i), 8'(m_act), 8'(tbl[i].occ != 3'd0));
        end
        // Without zeroing, the flushed output stage keeps its last data (0x01).
        check("zi0_flush_q", z_q, 8'h01);
        check("zi0_flush_qv", 8'(z_qv), 8'h00);
        check("zi0_flush_occ", 8'(z_occ), 8'h00);

        // Asynchronous reset with a full pipeline, asserted mid-cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
        check("full_occ", 8'(m_occ), 8'h04);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_q", m_q, 8'h00);
        check("async_rst_qv", 8'(m_qv), 8'h00);
        check("async_rst_occ", 8'(m_occ), 8'h00);
        check("async_rst_act", 8'(m_act), 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_q", m_q, 8'h00);
        check("rst_hold_occ", 8'(m_occ), 8'h00);
        model_reset();
        rst = 1'b0;

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 8'($urandom), 1'($urandom));
            check_model();
        end

        do_reset();
        step(1'b1, 1'b0, 8'h01, 1'b1);
        check("deg_load_q", 8'(g_q), 8'h01);
        check("deg_load_qv", 8'(g_qv), 8'h01);
        check("deg_load_occ", 8'(g_occ), 8'h01);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            check($sformatf("deg_hold%0d_q", i), 8'(g_q), 8'h01);
        end
        #3;
        rst = 1'b1;
        #1;
        check("deg_rst_q", 8'(g_q), 8'h00);
        check("deg_rst_qv", 8'(g_qv), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
